// File: rtl/tdm_demux_2ch.sv
// tdm_demux_2ch: routes a tagged input stream into two independent FWFT channel FIFOs
module tdm_demux_2ch #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   input  logic                     in_sel,
   output logic                     out0_valid,
   input  logic                     out0_ready,
   output logic [WIDTH-1:0]         out0_data,
   output logic [$clog2(DEPTH):0]   out0_count,
   output logic                     out1_valid,
   input  logic                     out1_ready,
   output logic [WIDTH-1:0]         out1_data,
   output logic [$clog2(DEPTH):0]   out1_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [WIDTH-1:0] mem_q [2][DEPTH];
   logic [WIDTH-1:0] mem_d [2][DEPTH];
   logic [AW-1:0]    wr_q [2];
   logic [AW-1:0]    wr_d [2];
   logic [AW-1:0]    rd_q [2];
   logic [AW-1:0]    rd_d [2];
   logic [CW-1:0]    cnt_q [2];
   logic [CW-1:0]    cnt_d [2];
   logic [1:0]       full, valid, rdy, push, pop;
   assign rdy = {out1_ready, out0_ready};
   always_comb begin
      for (int c = 0; c < 2; c++) begin
         full[c]  = cnt_q[c] == CW'(DEPTH);
         valid[c] = cnt_q[c] != '0;
      end
      in_ready = in_sel ? !full[1] : !full[0];
      push     = {in_sel, !in_sel} & {2{in_valid && in_ready}};
      pop      = valid & rdy;
   end
   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      for (int c = 0; c < 2; c++) begin
         if (push[c]) begin
            mem_d[c][wr_q[c]] = in_data;
            wr_d[c]           = wr_q[c] + 1'b1;
         end
         if (pop[c]) rd_d[c] = rd_q[c] + 1'b1;
         cnt_d[c] = cnt_q[c] + CW'(push[c]) - CW'(pop[c]);
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_q <= '{default: '0};
         wr_q  <= '{default: '0};
         rd_q  <= '{default: '0};
         cnt_q <= '{default: '0};
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end
   assign out0_valid = valid[0];
   assign out1_valid = valid[1];
   assign out0_data  = mem_q[0][rd_q[0]];
   assign out1_data  = mem_q[1][rd_q[1]];
   assign out0_count = cnt_q[0];
   assign out1_count = cnt_q[1];
endmodule

// File: tb/tb_tdm_demux_2ch.sv
// tb_tdm_demux_2ch: directed vector table plus wrap-around and mid-stream reset sequences
module tb_tdm_demux_2ch;
   logic       clk = 1'b0;
   logic       rst_n, in_valid, in_ready, in_sel;
   logic [7:0] in_data;
   logic       out0_valid, out0_ready, out1_valid, out1_ready;
   logic [7:0] out0_data, out1_data;
   logic [2:0] out0_count, out1_count;
   int         n_chk = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;

   tdm_demux_2ch #(.WIDTH(8), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_sel(in_sel),
      .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data), .out0_count(out0_count),
      .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data), .out1_count(out1_count)
   );

   typedef struct {
      logic       rst_n, iv, sel;
      logic [7:0] d;
      logic       r0, r1;
      logic       e_rdy, e_v0;
      logic [7:0] e_d0;
      logic [2:0] e_c0;
      logic       e_v1;
      logic [7:0] e_d1;
      logic [2:0] e_c1;
   } vec_t;

   vec_t tv [19];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic iv, input logic sel, input logic [7:0] d,
                       input logic r0, input logic r1);
      @(posedge clk);
      #1;
      rst_n = r; in_valid = iv; in_sel = sel; in_data = d; out0_ready = r0; out1_ready = r1;
      #3;
   endtask

   task automatic chk_all(input string p, input logic rdy, input logic v0, input logic [7:0] d0,
                          input logic [2:0] c0, input logic v1, input logic [7:0] d1, input logic [2:0] c1);
      chk({p, " in_ready"}, 32'(in_ready), 32'(rdy));
      chk({p, " out0_valid"}, 32'(out0_valid), 32'(v0));
      chk({p, " out0_count"}, 32'(out0_count), 32'(c0));
      chk({p, " out1_valid"}, 32'(out1_valid), 32'(v1));
      chk({p, " out1_count"}, 32'(out1_count), 32'(c1));
      chk({p, " out0_data"}, 32'(out0_data), 32'(d0));
      chk({p, " out1_data"}, 32'(out1_data), 32'(d1));
   endtask

   initial begin
      logic [7:0] q[$];
      int         sent, got;
      logic       tog, acc;
      // rst iv sel d  r0 r1 | rdy v0 d0 c0 v1 d1 c1 (outputs seen during the cycle the inputs are applied)
      tv[0]  = '{0,1,0,8'hFF,0,0, 1,0,8'h00,0, 0,8'h00,0};
      tv[1]  = '{0,1,1,8'hEE,0,0, 1,0,8'h00,0, 0,8'h00,0};
      tv[2]  = '{1,1,0,8'hA1,1,1, 1,0,8'h00,0, 0,8'h00,0};
      tv[3]  = '{1,1,1,8'hB2,1,1, 1,1,8'hA1,1, 0,8'h00,0};
      tv[4]  = '{1,1,0,8'hA3,1,1, 1,0,8'h00,0, 1,8'hB2,1};
      tv[5]  = '{1,0,0,8'h00,1,1, 1,1,8'hA3,1, 0,8'h00,0};
      tv[6]  = '{1,1,0,8'h10,0,0, 1,0,8'h00,0, 0,8'h00,0};
      tv[7]  = '{1,1,0,8'h11,0,0, 1,1,8'h10,1, 0,8'h00,0};
      tv[8]  = '{1,1,0,8'h12,0,0, 1,1,8'h10,2, 0,8'h00,0};
      tv[9]  = '{1,1,0,8'h13,0,0, 1,1,8'h10,3, 0,8'h00,0};
      tv[10] = '{1,1,0,8'h14,0,0, 0,1,8'h10,4, 0,8'h00,0};
      tv[11] = '{1,1,1,8'hC4,0,0, 1,1,8'h10,4, 0,8'h00,0};
      tv[12] = '{1,1,0,8'h14,1,0, 0,1,8'h10,4, 1,8'hC4,1};
      tv[13] = '{1,1,0,8'h14,0,0, 1,1,8'h11,3, 1,8'hC4,1};
      tv[14] = '{1,0,0,8'h00,1,1, 0,1,8'h11,4, 1,8'hC4,1};
      tv[15] = '{1,0,0,8'h00,1,0, 1,1,8'h12,3, 0,8'h00,0};
      tv[16] = '{1,0,0,8'h00,1,0, 1,1,8'h13,2, 0,8'h00,0};
      tv[17] = '{1,0,0,8'h00,1,0, 1,1,8'h14,1, 0,8'h00,0};
      tv[18] = '{1,0,0,8'h00,0,0, 1,0,8'h11,0, 0,8'h00,0};
      rst_n = 0; in_valid = 0; in_sel = 0; in_data = 0; out0_ready = 0; out1_ready = 0;
      @(posedge clk);
      for (int i = 0; i < 19; i++) begin
         step(tv[i].rst_n, tv[i].iv, tv[i].sel, tv[i].d, tv[i].r0, tv[i].r1);
         chk_all($sformatf("vec%0d", i), tv[i].e_rdy, tv[i].e_v0, tv[i].e_d0, tv[i].e_c0,
                 tv[i].e_v1, tv[i].e_d1, tv[i].e_c1);
      end
      // channel 1 wrap-around with a toggling consumer
      sent = 0; got = 0; tog = 1'b1;
      for (int cyc = 0; cyc < 100 && got < 10; cyc++) begin
         step(1, sent < 10, 1, 8'(sent), 0, tog);
         chk($sformatf("wrap%0d count", cyc), 32'(out1_count), 32'(q.size()));
         chk($sformatf("wrap%0d count_le_depth", cyc), 32'(out1_count <= 3'd4), 32'd1);
         chk($sformatf("wrap%0d valid", cyc), 32'(out1_valid), 32'(q.size() != 0));
         chk($sformatf("wrap%0d in_ready", cyc), 32'(in_ready), 32'(q.size() < 4));
         acc = (sent < 10) && (q.size() < 4);
         if (q.size() != 0 && tog) begin
            chk($sformatf("wrap%0d data", cyc), 32'(out1_data), 32'(q[0]));
            void'(q.pop_front());
            got++;
         end
         if (acc) begin
            q.push_back(8'(sent));
            sent++;
         end
         tog = !tog;
      end
      chk("wrap words_read", 32'(got), 32'd10);
      // mid-stream reset with both channels occupied
      step(1, 1, 0, 8'h31, 0, 0);
      step(1, 1, 0, 8'h32, 0, 0);
      step(1, 1, 0, 8'h33, 0, 0);
      step(1, 1, 1, 8'h41, 0, 0);
      step(1, 1, 1, 8'h42, 0, 0);
      step(1, 0, 0, 8'h00, 0, 0);
      chk("pre_rst out0_count", 32'(out0_count), 32'd3);
      chk("pre_rst out1_count", 32'(out1_count), 32'd2);
      step(0, 1, 0, 8'h77, 1, 1);
      step(1, 1, 0, 8'h5A, 0, 0);
      chk_all("post_rst", 1, 0, 8'h00, 0, 0, 8'h00, 0);
      step(1, 0, 0, 8'h00, 0, 0);
      chk_all("first_after_rst", 1, 1, 8'h5A, 1, 0, 8'h00, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/tdm_demux_2ch.md
# tdm_demux_2ch

Buffered 1-to-2 demultiplexer: the receive-side counterpart of the 2:1 mux. It accepts a single tagged stream (`in_data` plus `in_sel` channel tag) under valid/ready handshake and routes each word into one of two per-channel FIFOs. Each FIFO drains independently through its own valid/ready output port. It sits after any stage that time-multiplexes two producers onto one bus, and restores the two streams with per-channel ordering preserved.

## Interface
- `WIDTH`, default 8: data width of the input and both outputs.
- `DEPTH`, default 4: entries per channel FIFO; must be a power of two and at least 2.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  input word accepted this cycle if `in_valid` is also high.
- `in_data`  in  WIDTH  input word.
- `in_sel`  in  1  destination tag: 0 routes to channel 0, 1 routes to channel 1.
- `out0_valid` / `out1_valid`  out  1  channel FIFO not empty.
- `out0_ready` / `out1_ready`  in  1  consumer accepts the head word.
- `out0_data` / `out1_data`  out  WIDTH  head word of the channel FIFO.
- `out0_count` / `out1_count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- **Per-channel storage:** DEPTH x WIDTH register array, write pointer, read pointer, occupancy counter. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
- **Input ready:** `in_ready = (in_sel ? !full1 : !full0)`. This is combinational from `in_sel`. Readiness does not depend on `in_valid`.
- **Push:** when `in_valid && in_ready`, write `in_data` at the selected channel's write pointer, increment that pointer, and increment the count. The other channel is untouched.
- **Pop:** when `outN_valid && outN_ready`, increment the read pointer and decrement the count. `outN_data` = storage[read pointer] (first-word-fall-through).
- **Simultaneous push and pop on one channel:** the count is unchanged and both pointers advance.
- **Full channel:**
  - No push to a full channel, even if a pop occurs in the same cycle. There is no bypass, so `in_ready` low is driven by `full` alone.
  - A full channel blocks only inputs tagged for it. The other channel keeps accepting.
- **Empty channel:** `outN_valid` is low and `outN_ready` is ignored. No underflow is possible.
- **Ordering:** strict FIFO order within a channel. There is no ordering relation between channels.
- **Counter arithmetic:** counts never exceed DEPTH or go below 0 under any input combination.
- **Reset (`rst_n` low at a clock edge):**
  - Pointers and counts go to 0 and all storage is cleared to 0.
  - Next-cycle outputs: `out0_valid = out1_valid = 0`, `out0_data = out1_data = 0`, `out0_count = out1_count = 0`, `in_ready = 1`.
  - Reset overrides any push or pop in the same cycle. In-flight buffered words are discarded.

## Timing
- **Latency:** 1 cycle. A word pushed at edge k appears on `outN_data` with `outN_valid` high after edge k; it is consumable in cycle k+1.
- **Throughput:** one input word per cycle. Each output sustains one word per cycle while non-empty.
- **Ready after pop on a full channel:** a pop at edge k makes `in_ready` for that channel high after edge k, not during cycle k.
- **Count timing:** `outN_count` is registered and reflects all pushes and pops up to the last edge.
- **Combinational paths:**
  - `in_sel` to `in_ready`, one mux level.
  - read pointer to `outN_data`, one DEPTH:1 mux.
  - No path from `outN_ready` to `in_ready`.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles with `in_valid`=1 -> all valid 0, counts 0, data 0, `in_ready`=1, nothing stored after release.
- **Routing:** push 0xA1 (sel 0), 0xB2 (sel 1), 0xA3 (sel 0), with both outputs ready -> out0 yields 0xA1 then 0xA3, out1 yields 0xB2, each 1 cycle after acceptance.
- **Full and isolation:** `out0_ready`=0, push 5 words sel 0 with DEPTH=4 -> `out0_count`=4, the 5th is held with `in_ready`=0. Switch `in_sel`=1 -> `in_ready`=1 and 0xC4 is accepted on channel 1.
- **Full with pop:** on a full channel 0, assert `out0_ready` and `in_valid` (sel 0) in the same cycle -> head pops, push rejected that cycle, accepted next cycle, count 4 -> 3 -> 4.
- **Wrap-around:** stream 10 words 0x00..0x09 into channel 1 with `out1_ready` toggling 1,0,1,0 -> all 10 are read in order and the count never exceeds 4.
- **Mid-stream reset:** with channel 0 count 3 and channel 1 count 2, pulse `rst_n` low 1 cycle -> both counts 0 and both valids 0. A subsequent push sel 0 of 0x5A is the first word out.
